bin2bcd_seq: RTL and testbench

// - Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the 6-digit seven-segment display path.
// - Sits upstream of the per-digit seg_decoder instances; turns a binary value into DIGITS packed BCD nibbles.
// - Start/busy/done handshake; result is held stable between conversions so the display does not flicker.

---
 rtl/bin2bcd_seq.sv | 150 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using shift-and-add-3.
// One binary bit is consumed per clock. The result and overflow flag stay
// stable between conversions so the downstream display does not flicker.
// Optional feature macro: BIN2BCD_BLANK_EN adds a leading-zero blanking
// mask output (blank). Without the macro, that port and its logic are absent.
module bin2bcd_seq #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
`ifdef BIN2BCD_BLANK_EN
    output logic [DIGITS-1:0]     blank,
`endif
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    // Scratch holds DIGITS result nibbles plus one guard nibble that catches overflow.
    localparam int SW    = 4 * (DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [SW-1:0]          scratch_q;
    logic [BIN_W-1:0]       shreg_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ovf_q;
    logic [4*DIGITS-1:0]    bcd_q;

    logic [SW-1:0]          scratch_adj;
    logic [SW+BIN_W-1:0]    cat_sh;
    logic [SW-1:0]          scratch_d;
    logic [BIN_W-1:0]       shreg_d;
    logic                   ovf_d;
    logic [4*DIGITS-1:0]    bcd_d;
    logic [4*DIGITS-1:0]    nines;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]      blank_q;
    logic [DIGITS-1:0]      blank_d;
`endif

    // Add-3 correction per nibble (no inter-nibble carry), then one-bit left shift.
    always_comb begin
        scratch_adj = scratch_q;
        for (int unsigned i = 0; i < DIGITS + 1; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        cat_sh    = {scratch_adj, shreg_q} << 1;
        scratch_d = cat_sh[SW+BIN_W-1 -: SW];
        shreg_d   = cat_sh[BIN_W-1:0];
    end

    // Final result: saturate to all 9s when the guard nibble is non-zero.
    always_comb begin
        nines = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nines[4*i +: 4] = 4'd9;
        end
        ovf_d = (scratch_q[SW-1 -: 4] != 4'd0);
        bcd_d = ovf_d ? nines : scratch_q[4*DIGITS-1:0];
    end

`ifdef BIN2BCD_BLANK_EN
    // Leading-zero mask: digit k blanks when it and every higher digit are zero; digit 0 never blanks.
    always_comb begin
        logic hi_zero;
        blank_d = '0;
        hi_zero = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            hi_zero    = hi_zero && (scratch_q[4*k +: 4] == 4'd0);
            blank_d[k] = hi_zero && !ovf_d;
        end
    end
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            scratch_q <= '0;
            shreg_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
`ifdef BIN2BCD_BLANK_EN
            blank_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shreg_q   <= bin_in;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(BIN_W);
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    busy_q    <= 1'b1;
                    scratch_q <= scratch_d;
                    shreg_q   <= shreg_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FINISH;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    ovf_q   <= ovf_d;
                    bcd_q   <= bcd_d;
`ifdef BIN2BCD_BLANK_EN
                    blank_q <= blank_d;
`endif
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd_out  = bcd_q;
`ifdef BIN2BCD_BLANK_EN
    assign blank    = blank_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed vectors, a cycle-level arithmetic model
// compared every cycle, and hand-computed literal expectations.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 20;
    localparam int DIGITS = 6;
    localparam int MAXV   = 999999;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [BIN_W-1:0]     bin_in;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic [4*DIGITS-1:0]  bcd_out;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]    blank;
`endif

    int errors = 0;
    int checks = 0;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
`ifdef BIN2BCD_BLANK_EN
        .blank    (blank),
`endif
        .bcd_out  (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int t;
        t = v;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] blank_of(input int v);
        logic [DIGITS-1:0] b;
        int p;
        b = '0;
        p = 10;
        for (int k = 1; k < DIGITS; k++) begin
            b[k] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    // Behavioural model: a conversion accepted at an edge completes BIN_W+1 edges later.
    logic        m_active = 1'b0;
    int          m_age    = 0;
    int          m_val    = 0;
    logic        m_busy   = 1'b0;
    logic        m_done   = 1'b0;
    logic        m_ovf    = 1'b0;
    logic [23:0] m_bcd    = '0;
    logic [5:0]  m_blank  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_age = 0; m_busy = 1'b0; m_done = 1'b0;
            m_ovf = 1'b0; m_bcd = '0; m_blank = '0;
        end else if (m_active) begin
            m_age++;
            if (m_age <= BIN_W) begin
                m_busy = 1'b1;
            end else begin
                m_busy   = 1'b0;
                m_done   = 1'b1;
                m_active = 1'b0;
                if (m_val > MAXV) begin
                    m_ovf = 1'b1; m_bcd = 24'h999999; m_blank = '0;
                end else begin
                    m_ovf = 1'b0; m_bcd = to_bcd(m_val); m_blank = blank_of(m_val);
                end
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_active = 1'b1;
                m_age    = 0;
                m_val    = int'(bin_in);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("bcd_out", 32'(bcd_out), 32'(m_bcd));
`ifdef BIN2BCD_BLANK_EN
        check("blank", 32'(blank), 32'(m_blank));
`endif
    end

    task automatic pulse_start(input int v);
        @(posedge clk); #1;
        start  = 1'b1;
        bin_in = BIN_W'(v);
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        int   k;
        logic found;
        k = 0; bc = 0; found = 1'b0;
        while (k < 60 && !found) begin
            @(posedge clk); #1;
            k++;
            if (busy) bc++;
            if (done) found = 1'b1;
        end
        check("done_seen", 32'(found), 32'd1);
        lat = k;
    endtask

    initial begin
        int lat, bc, nd;
        rst_n = 1'b0; start = 1'b0; bin_in = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        pulse_start(123456);
        wait_done(lat, bc);
        check("lat_123456", 32'(lat), 32'd21);
        check("busy_cycles", 32'(bc), 32'd20);
        check("bcd_123456", 32'(bcd_out), 32'h123456);
        check("ovf_123456", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);

        pulse_start(0);
        wait_done(lat, bc);
        check("bcd_0", 32'(bcd_out), 32'h000000);
        check("ovf_0", 32'(overflow), 32'd0);
`ifdef BIN2BCD_BLANK_EN
        check("blank_0", 32'(blank), 32'b111110);
`endif

        pulse_start(999999);
        wait_done(lat, bc);
        check("bcd_999999", 32'(bcd_out), 32'h999999);
        check("ovf_999999", 32'(overflow), 32'd0);

        pulse_start(1048575);
        wait_done(lat, bc);
        check("bcd_sat", 32'(bcd_out), 32'h999999);
        check("ovf_sat", 32'(overflow), 32'd1);
        repeat (5) @(posedge clk); #1;
        check("ovf_hold", 32'(overflow), 32'd1);

        pulse_start(42);
        wait_done(lat, bc);
        check("bcd_42", 32'(bcd_out), 32'h000042);
        check("ovf_42", 32'(overflow), 32'd0);
`ifdef BIN2BCD_BLANK_EN
        check("blank_42", 32'(blank), 32'b111100);
`endif

        // Start while busy must be ignored.
        pulse_start(7);
        @(posedge clk); #1;
        start = 1'b1; bin_in = BIN_W'(55);
        @(posedge clk); #1;
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("busy_ignore_dones", 32'(nd), 32'd1);
        check("bcd_7", 32'(bcd_out), 32'h000007);

        // Asynchronous reset mid-conversion.
        pulse_start(123456);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'd0);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        rst_n = 1'b1;
        pulse_start(500);
        wait_done(lat, bc);
        check("lat_500", 32'(lat), 32'd21);
        check("bcd_500", 32'(bcd_out), 32'h000500);

        // Start held high: back-to-back conversions every BIN_W+2 cycles.
        @(posedge clk); #1;
        start = 1'b1; bin_in = BIN_W'(999);
        for (int r = 0; r < 3; r++) begin
            wait_done(lat, bc);
            check("hold_period", 32'(lat), 32'd22);
            check("hold_bcd", 32'(bcd_out), 32'h000999);
        end
        start = 1'b0;
        repeat (30) @(posedge clk); #1;
        check("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
